// File: rtl/sboxlayer_seq.sv
// Multi-cycle PRESENT S-box layer. Substitutes LANES nibbles per clock,
// lowest nibble group first, with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | substituting one group of LANES nibbles per clock
// DONE  | result presented on dataout; held until out_ready
module sboxlayer_seq #(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inv,
  input  logic [WIDTH-1:0] datain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             busy
);

  localparam int NNIB = WIDTH / 4;
  localparam int NCYC = (LANES > 0) ? (NNIB / LANES) : 1;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("sboxlayer_seq: WIDTH must be a positive multiple of 4");
  end
  if ((LANES < 1) || ((NNIB % LANES) != 0)) begin : g_bad_lanes
    $error("sboxlayer_seq: LANES must divide WIDTH/4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sub_next;
  logic [CW-1:0]    cnt;
  logic             mode;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // State register with the current nibble group substituted in place
  always_comb begin
    sub_next = sreg;
    for (int l = 0; l < LANES; l++) begin
      sub_next[(int'(cnt) * LANES + l) * 4 +: 4] =
        mode ? sbox_inv(sreg[(int'(cnt) * LANES + l) * 4 +: 4])
             : sbox_fwd(sreg[(int'(cnt) * LANES + l) * 4 +: 4]);
    end
  end

  // Sequencer: accept a block, walk the nibble groups, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      mode        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg       <= datain;
            mode       <= inv;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sreg <= sub_next;
          if (cnt == CW'(NCYC - 1)) begin
            cnt         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dataout   = sreg;

endmodule

// File: tb/tb_sboxlayer_seq.sv
// Bench for sboxlayer_seq: four parameterisations side by side, directed
// checks on the 64/4 instance, then random traffic on all of them.
module tb_sboxlayer_seq;

  localparam logic [3:0] SF [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] SI [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                     4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv     [4];
  logic         ir     [4];
  logic         inv_s  [4];
  logic [127:0] din    [4];
  logic         ov     [4];
  logic         ordy   [4];
  logic [127:0] dout_w [4];
  logic         bsy    [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pending [4];
  bit rnd_done = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] model(input logic [127:0] d, input logic m, input int w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w / 4; i++) r[i*4 +: 4] = m ? SI[d[i*4 +: 4]] : SF[d[i*4 +: 4]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int W = (g == 3) ? 128 : 64;
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 8;
    localparam int N = W / (4 * L);
    logic [W-1:0] dq;
    logic [127:0] expq [$];
    int           accq [$];
    bit           prev_ov;

    sboxlayer_seq #(.WIDTH(W), .LANES(L)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[g]), .in_ready(ir[g]), .inv(inv_s[g]), .datain(din[g][W-1:0]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .dataout(dq), .busy(bsy[g]));

    assign dout_w[g] = 128'(dq);

    // Monitor: record accepts with their expected result, check latency and data
    initial begin
      prev_ov = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          expq.delete();
          accq.delete();
          prev_ov = 1'b0;
          pending[g] = 0;
        end else begin
          if (ov[g] && !prev_ov) begin
            if (accq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL spurious_ov%0d: got out_valid want idle", g);
            end else chk($sformatf("latency%0d", g), 128'(cyc - accq[0]), 128'(N));
          end
          if (ov[g] && ordy[g] && expq.size() > 0) begin
            chk($sformatf("data%0d", g), dout_w[g], expq.pop_front());
            accq.delete(0);
            pending[g]--;
          end
          if (iv[g] && ir[g]) begin
            expq.push_back(model(din[g], inv_s[g], W));
            accq.push_back(cyc + 1);
            pending[g]++;
          end
          prev_ov = ov[g];
        end
      end
    end
  end

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic send0(input logic [127:0] d, input logic m, output int a);
    int w;
    @(posedge clk); #1;
    iv[0] = 1'b1; din[0] = d; inv_s[0] = m;
    w = 0;
    @(negedge clk);
    while (!ir[0] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ir[0]) fail_now("accept0");
    a = cyc + 1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    din[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    inv_s[0] = ~m;
  endtask

  task automatic dir(input logic [127:0] d, input logic m, input logic [127:0] e);
    int a;
    send0(d, m, a);
    wait_neg(a + 3);
    chk("early_ov", 128'(ov[0]), 128'(0));
    @(negedge clk);
    chk("lat_ov", 128'(ov[0]), 128'(1));
    chk("dir_data", dout_w[0], e);
    chk("done_ir", 128'(ir[0]), 128'(0));
    @(negedge clk);
    chk("ir_back", 128'(ir[0]), 128'(1));
    chk("ov_drop", 128'(ov[0]), 128'(0));
  endtask

  task automatic drive_random(input int k, input int n);
    int idle;
    int w;
    for (int v = 0; v < n; v++) begin
      idle = int'($urandom_range(2));
      repeat (idle) @(posedge clk);
      @(posedge clk); #1;
      iv[k] = 1'b1;
      din[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv_s[k] = 1'($urandom_range(1));
      w = 0;
      @(negedge clk);
      while (!ir[k] && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!ir[k]) begin
        fail_now($sformatf("accept%0d", k));
        break;
      end
      @(posedge clk); #1;
      iv[k] = 1'b0;
      din[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv_s[k] = 1'($urandom_range(1));
    end
  endtask

  initial begin
    int a;
    int w;
    int sum;
    logic [127:0] d;
    logic [127:0] v;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; inv_s[k] = 1'b0; din[k] = '0; ordy[k] = 1'b1; pending[k] = 0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_ir", 128'(ir[k]), 128'(1));
      chk("rst_ov", 128'(ov[k]), 128'(0));
      chk("rst_busy", 128'(bsy[k]), 128'(0));
      chk("rst_dout", dout_w[k], 128'(0));
    end
    #1 rst_n = 1'b1;

    dir(128'h0123456789ABCDEF, 1'b0, 128'hC56B90AD3EF84712);
    dir(128'hC56B90AD3EF84712, 1'b1, 128'h0123456789ABCDEF);
    dir(128'h0, 1'b0, 128'hCCCCCCCCCCCCCCCC);
    dir(128'hFFFFFFFFFFFFFFFF, 1'b1, 128'hAAAAAAAAAAAAAAAA);

    // inputs churn while the block is in flight
    d = {64'h0, $urandom(), $urandom()};
    send0(d, 1'b1, a);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      din[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv_s[0] = ~inv_s[0];
    end
    wait_neg(a + 4);
    chk("iso_data", dout_w[0], model(d, 1'b1, 64));
    @(negedge clk);

    // backpressure
    ordy[0] = 1'b0;
    send0(128'hFFFFFFFFFFFFFFFF, 1'b0, a);
    wait_neg(a + 4);
    v = dout_w[0];
    chk("bp_data", v, 128'h2222222222222222);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      iv[0] = (i % 2 == 0);
      din[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      chk("bp_ov", 128'(ov[0]), 128'(1));
      chk("bp_ir", 128'(ir[0]), 128'(0));
      chk("bp_hold", dout_w[0], v);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_ov_last", 128'(ov[0]), 128'(1));
    @(negedge clk);
    chk("bp_ov_drop", 128'(ov[0]), 128'(0));
    chk("bp_ir_back", 128'(ir[0]), 128'(1));
    chk("bp_busy", 128'(bsy[0]), 128'(0));

    // reset in the middle of RUN
    send0({64'h0, $urandom(), $urandom()}, 1'b0, a);
    wait_neg(a + 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", 128'(ir[0]), 128'(1));
    chk("mid_rst_ov", 128'(ov[0]), 128'(0));
    chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
    chk("mid_rst_dout", dout_w[0], 128'(0));
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", 128'(ov[0]), 128'(0));
    end
    dir(128'hC56B90AD3EF84712, 1'b1, 128'h0123456789ABCDEF);

    // random traffic on every parameterisation
    fork
      begin
        fork
          drive_random(0, 300);
          drive_random(1, 1000);
          drive_random(2, 1000);
          drive_random(3, 1000);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(3) != 0);
        end
      end
    join
    for (int k = 0; k < 4; k++) ordy[k] = 1'b1;

    w = 0;
    do begin
      @(negedge clk);
      w++;
      sum = 0;
      for (int k = 0; k < 4; k++) sum += pending[k];
    end while (sum > 0 && w < 500);
    if (sum > 0) fail_now("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
